// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: parametrised 3-stage floating-point multiplier.
// S1 unpacks/classifies, S2 forms the full significand product,
// S3 normalises, rounds (nearest-even) and packs the result with flags.
// Subnormal inputs read as signed zero; tiny results flush to signed zero.
module fp_mult_pipe #(
   parameter  int EXP_W = 8,
   parameter  int MAN_W = 23,
   localparam int W     = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a_operand,
   input  logic [W-1:0] b_operand,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic         invalid,
   output logic         overflow,
   output logic         underflow,
   output logic         inexact
);

   localparam int PW = 2*MAN_W + 2;   // product width
   localparam int XW = EXP_W + 2;     // signed working exponent width

   localparam logic signed [XW-1:0] BIAS    = XW'((1 << (EXP_W-1)) - 1);
   localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
   localparam logic [W-1:0]         QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   // ---------------- flow control ----------------
   logic s1_v_q, s2_v_q, s3_v_q;
   logic s1_v_d, s2_v_d, s3_v_d;
   logic s1_open, s2_open, s3_open;
   logic ld1, ld2, ld3;

   // A stage can take new contents when empty or when its own contents leave.
   assign s3_open  = !s3_v_q | out_ready;
   assign s2_open  = !s2_v_q | s3_open;
   assign s1_open  = !s1_v_q | s2_open;
   assign in_ready = s1_open;

   assign s1_v_d = s1_open ? in_valid : s1_v_q;
   assign s2_v_d = s2_open ? s1_v_q   : s2_v_q;
   assign s3_v_d = s3_open ? s2_v_q   : s3_v_q;

   // data registers only load when a real entry moves in
   assign ld1 = s1_open & in_valid;
   assign ld2 = s2_open & s1_v_q;
   assign ld3 = s3_open & s2_v_q;

   // ---------------- S1: unpack and classify ----------------
   logic               s_a, s_b;
   logic [EXP_W-1:0]   e_a, e_b;
   logic [MAN_W-1:0]   m_a, m_b;
   logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic               sign_d;
   logic               spec_d, sinv_d;
   logic [W-1:0]       sres_d;
   logic signed [XW-1:0] exp_d;

   assign {s_a, e_a, m_a} = a_operand;
   assign {s_b, e_b, m_b} = b_operand;

   assign a_zero = ~|e_a;                 // zero or subnormal (DAZ)
   assign b_zero = ~|e_b;
   assign a_nan  = (&e_a) &  (|m_a);
   assign b_nan  = (&e_b) &  (|m_b);
   assign a_inf  = (&e_a) & ~(|m_a);
   assign b_inf  = (&e_b) & ~(|m_b);
   assign sign_d = s_a ^ s_b;
   assign exp_d  = $signed({2'b00, e_a}) + $signed({2'b00, e_b}) - BIAS;

   // Special-operand result, in priority order NaN/Inf*0, Inf, zero.
   always_comb begin
      spec_d = 1'b0;
      sinv_d = 1'b0;
      sres_d = '0;
      if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
         spec_d = 1'b1;
         sinv_d = 1'b1;
         sres_d = QNAN;
      end else if (a_inf | b_inf) begin
         spec_d = 1'b1;
         sres_d = {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (a_zero | b_zero) begin
         spec_d = 1'b1;
         sres_d = {sign_d, {(W-1){1'b0}}};
      end
   end

   logic                 s1_sign_q, s1_spec_q, s1_inv_q;
   logic [W-1:0]         s1_sres_q;
   logic signed [XW-1:0] s1_exp_q;
   logic [MAN_W:0]       s1_siga_q, s1_sigb_q;

   // S1 register: classification and significands with hidden bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q    <= 1'b0;
         s1_sign_q <= 1'b0;
         s1_spec_q <= 1'b0;
         s1_inv_q  <= 1'b0;
         s1_sres_q <= '0;
         s1_exp_q  <= '0;
         s1_siga_q <= '0;
         s1_sigb_q <= '0;
      end else begin
         s1_v_q <= s1_v_d;
         if (ld1) begin
            s1_sign_q <= sign_d;
            s1_spec_q <= spec_d;
            s1_inv_q  <= sinv_d;
            s1_sres_q <= sres_d;
            s1_exp_q  <= exp_d;
            s1_siga_q <= {1'b1, m_a};
            s1_sigb_q <= {1'b1, m_b};
         end
      end
   end

   // ---------------- S2: significand product ----------------
   logic [PW-1:0]        prod_d;
   logic                 s2_sign_q, s2_spec_q, s2_inv_q;
   logic [W-1:0]         s2_sres_q;
   logic signed [XW-1:0] s2_exp_q;
   logic [PW-1:0]        s2_prod_q;

   assign prod_d = PW'(s1_siga_q) * PW'(s1_sigb_q);

   // S2 register: full-width product, classification carried along.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v_q    <= 1'b0;
         s2_sign_q <= 1'b0;
         s2_spec_q <= 1'b0;
         s2_inv_q  <= 1'b0;
         s2_sres_q <= '0;
         s2_exp_q  <= '0;
         s2_prod_q <= '0;
      end else begin
         s2_v_q <= s2_v_d;
         if (ld2) begin
            s2_sign_q <= s1_sign_q;
            s2_spec_q <= s1_spec_q;
            s2_inv_q  <= s1_inv_q;
            s2_sres_q <= s1_sres_q;
            s2_exp_q  <= s1_exp_q;
            s2_prod_q <= prod_d;
         end
      end
   end

   // ---------------- S3: normalise, round, pack ----------------
   logic                 msb, grd, stk, inc, ovf, unf;
   logic [MAN_W-1:0]     man;
   logic [MAN_W:0]       man_r;
   logic signed [XW-1:0] exp_n, exp_f;
   logic [W-1:0]         res_d;
   logic [3:0]           flg_d;   // {invalid, overflow, underflow, inexact}

   // Product is in [1,4): pick the mantissa window by the top bit, then RNE.
   always_comb begin
      msb   = s2_prod_q[PW-1];
      man   = msb ? s2_prod_q[PW-2 -: MAN_W] : s2_prod_q[PW-3 -: MAN_W];
      grd   = msb ? s2_prod_q[MAN_W]         : s2_prod_q[MAN_W-1];
      stk   = msb ? |s2_prod_q[MAN_W-1:0]    : |s2_prod_q[MAN_W-2:0];
      exp_n = s2_exp_q + $signed({{(XW-1){1'b0}}, msb});
      inc   = grd & (stk | man[0]);
      man_r = {1'b0, man} + {{MAN_W{1'b0}}, inc};
      // carry out of the hidden bit leaves man_r[MAN_W-1:0] all zero
      exp_f = exp_n + $signed({{(XW-1){1'b0}}, man_r[MAN_W]});
      ovf   = !exp_f[XW-1] && (exp_f >= EXP_MAX);
      unf   = exp_f[XW-1] || (exp_f == '0);

      res_d = '0;
      flg_d = '0;
      if (s2_spec_q) begin
         res_d = s2_sres_q;
         flg_d = {s2_inv_q, 3'b000};
      end else if (ovf) begin
         res_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flg_d = 4'b0101;
      end else if (unf) begin
         res_d = {s2_sign_q, {(W-1){1'b0}}};
         flg_d = 4'b0011;
      end else begin
         res_d = {s2_sign_q, exp_f[EXP_W-1:0], man_r[MAN_W-1:0]};
         flg_d = {3'b000, grd | stk};
      end
   end

   logic [W-1:0] s3_res_q;
   logic [3:0]   s3_flg_q;

   // S3 register: packed result and its flags; held while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3_v_q   <= 1'b0;
         s3_res_q <= '0;
         s3_flg_q <= '0;
      end else begin
         s3_v_q <= s3_v_d;
         if (ld3) begin
            s3_res_q <= res_d;
            s3_flg_q <= flg_d;
         end
      end
   end

   // Outputs read zero whenever no result is presented.
   assign out_valid = s3_v_q;
   assign result    = s3_v_q ? s3_res_q : '0;
   assign invalid   = s3_v_q & s3_flg_q[3];
   assign overflow  = s3_v_q & s3_flg_q[2];
   assign underflow = s3_v_q & s3_flg_q[1];
   assign inexact   = s3_v_q & s3_flg_q[0];

endmodule
